vm_restock_loader: RTL

VM_RESTOCK_LOADER -- requirements
Module: vm_restock_loader

---
 rtl/vm_pkg.sv | 31 +++
 rtl/vm_shadow_table.sv | 66 ++++++
 rtl/vm_restock_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared sizes, types and request checks for the vending-machine restock loader.
package vm_pkg;
  localparam int unsigned NUM_SLOTS = 6;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned COUNT_W   = 4;
  localparam int unsigned COST_W    = 8;
  localparam int unsigned COUNT_MAX = 15;

  typedef logic [SLOT_W-1:0]  slot_t;
  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [COST_W-1:0]  cost_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DRIVE, ST_GAP} ld_state_t;

  typedef struct packed {
    slot_t  slot;
    count_t qty;
    cost_t  cost;
    logic   add;
    logic   refresh;
  } ld_req_t;

  function automatic logic slot_ok(slot_t s);
    return s < SLOT_W'(NUM_SLOTS);
  endfunction

  // A set must carry a non-zero price; any request must name a real slot.
  function automatic logic req_reject(slot_t s, cost_t c, logic add);
    return !slot_ok(s) || (c == '0 && !add);
  endfunction
endpackage

// File: rtl/vm_shadow_table.sv
// Shadow copy of per-slot count/cost with one write port and a sale-decrement
// port; a same-cycle write and sale to one slot commit as write-then-decrement.
module vm_shadow_table
  import vm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SLOT_W-1:0]  wr_slot,
  input  logic [COUNT_W-1:0] wr_count,
  input  logic [COST_W-1:0]  wr_cost,
  input  logic               sold_valid,
  input  logic [SLOT_W-1:0]  sold_slot,
  input  logic [SLOT_W-1:0]  rd_slot,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COST_W-1:0]  rd_cost,
  output logic [COUNT_W-1:0] rd_count_nxt,
  output logic [COST_W-1:0]  rd_cost_nxt,
  output logic               underflow
);
  count_t cnt_q  [NUM_SLOTS];
  cost_t  cost_q [NUM_SLOTS];
  count_t cnt_d  [NUM_SLOTS];
  cost_t  cost_d [NUM_SLOTS];
  logic   uf_d;
  logic   rd_ok;

  // Next table contents: write first, then apply the sale to the result.
  always_comb begin
    uf_d = underflow;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cnt_d[i]  = cnt_q[i];
      cost_d[i] = cost_q[i];
      if (wr_en && wr_slot == SLOT_W'(i)) begin
        cnt_d[i]  = wr_count;
        cost_d[i] = wr_cost;
      end
      if (sold_valid && sold_slot == SLOT_W'(i)) begin
        if (cnt_d[i] == '0) uf_d = 1'b1;
        else                cnt_d[i] = cnt_d[i] - COUNT_W'(1);
      end
    end
  end

  assign rd_ok        = slot_ok(rd_slot);
  assign rd_count     = rd_ok ? cnt_q[rd_slot]  : '0;
  assign rd_cost      = rd_ok ? cost_q[rd_slot] : '0;
  assign rd_count_nxt = rd_ok ? cnt_d[rd_slot]  : '0;
  assign rd_cost_nxt  = rd_ok ? cost_d[rd_slot] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cnt_q[i]  <= '0;
        cost_q[i] <= '0;
      end
      underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        cost_q[i] <= cost_d[i];
      end
      underflow <= uf_d;
    end
  end
endmodule

// File: rtl/vm_restock_loader.sv
// Restock loader: accepts host set/add/refresh requests, keeps the shadow
// table current and streams supplier records as DRIVE/GAP pairs.
module vm_restock_loader
  import vm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SLOT_W-1:0]  req_slot,
  input  logic [COUNT_W-1:0] req_qty,
  input  logic [COST_W-1:0]  req_cost,
  input  logic               req_add,
  input  logic               req_refresh,
  input  logic               sold_valid,
  input  logic [SLOT_W-1:0]  sold_slot,
  output logic [SLOT_W-1:0]  items,
  output logic [COUNT_W-1:0] count,
  output logic [COST_W-1:0]  cost,
  output logic               valid,
  output logic               busy,
  output logic               err,
  output logic               sat,
  output logic               underflow
);
  localparam count_t CNT_MAX = COUNT_W'(COUNT_MAX);

  ld_state_t state_q, state_d;
  ld_req_t   req_q, req_d;
  slot_t     ref_q, ref_d;
  slot_t     items_d;
  count_t    count_d;
  cost_t     cost_d;
  logic      valid_d, busy_d, err_d, sat_d, ready_d;

  slot_t            rd_slot;
  count_t           rd_count, rd_count_nxt;
  cost_t            rd_cost, rd_cost_nxt;
  logic             wr_en;
  count_t           wr_count;
  cost_t            wr_cost;
  logic             accept;
  logic [COUNT_W:0] sum_pred, sum_calc;

  assign accept   = req_valid && req_ready;
  assign sum_pred = {1'b0, rd_count_nxt} + {1'b0, req_qty};
  assign sum_calc = {1'b0, rd_count} + {1'b0, req_q.qty};

  vm_shadow_table u_table (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_slot      (req_q.slot),
    .wr_count     (wr_count),
    .wr_cost      (wr_cost),
    .sold_valid   (sold_valid),
    .sold_slot    (sold_slot),
    .rd_slot      (rd_slot),
    .rd_count     (rd_count),
    .rd_cost      (rd_cost),
    .rd_count_nxt (rd_count_nxt),
    .rd_cost_nxt  (rd_cost_nxt),
    .underflow    (underflow)
  );

  // Table port steering; kept apart from the FSM so it never reads rd_*_nxt.
  always_comb begin
    rd_slot  = req_slot;
    wr_en    = 1'b0;
    wr_count = '0;
    wr_cost  = '0;
    case (state_q)
      ST_CALC: begin
        rd_slot = req_q.refresh ? '0 : req_q.slot;
        if (!req_q.refresh && !req_reject(req_q.slot, req_q.cost, req_q.add)) begin
          wr_en    = 1'b1;
          wr_count = !req_q.add                  ? req_q.qty :
                     (sum_calc > {1'b0, CNT_MAX}) ? CNT_MAX   : sum_calc[COUNT_W-1:0];
          wr_cost  = (!req_q.add || rd_cost == '0) ? req_q.cost : rd_cost;
        end
      end
      ST_GAP:  rd_slot = ref_q;
      default: ;
    endcase
  end

  // Next state and output-register values; err/sat are decided at acceptance
  // so their pulses land in the CALC cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ref_d   = ref_q;
    items_d = items;
    count_d = count;
    cost_d  = cost;
    err_d   = 1'b0;
    sat_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CALC;
          req_d   = '{slot: req_slot, qty: req_qty, cost: req_cost,
                      add: req_add, refresh: req_refresh};
          ref_d   = '0;
          if (!req_refresh) begin
            err_d = req_reject(req_slot, req_cost, req_add);
            sat_d = !err_d && req_add && (sum_pred > {1'b0, CNT_MAX});
          end
        end
      end
      ST_CALC: begin
        state_d = ST_DRIVE;
        if (!req_q.refresh && req_reject(req_q.slot, req_q.cost, req_q.add)) begin
          state_d = ST_IDLE;
        end else begin
          items_d = rd_slot;
          count_d = rd_count_nxt;
          cost_d  = rd_cost_nxt;
          ref_d   = SLOT_W'(1);
        end
      end
      ST_DRIVE: state_d = ST_GAP;
      ST_GAP: begin
        if (req_q.refresh && slot_ok(ref_q)) begin
          state_d = ST_DRIVE;
          items_d = ref_q;
          count_d = rd_count_nxt;
          cost_d  = rd_cost_nxt;
          ref_d   = ref_q + SLOT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_DRIVE);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      ref_q     <= '0;
      items     <= '0;
      count     <= '0;
      cost      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      sat       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ref_q     <= ref_d;
      items     <= items_d;
      count     <= count_d;
      cost      <= cost_d;
      valid     <= valid_d;
      busy      <= busy_d;
      err       <= err_d;
      sat       <= sat_d;
      req_ready <= ready_d;
    end
  end
endmodule
